// File: rtl/dpram_nibble_pipe.sv
// -----------------------------------------------------------------------------
// dpram_nibble_pipe
//
// Single-clock true dual-port RAM with per-lane write enables, write-first
// cross-port forwarding, deterministic write-write arbitration (port A wins
// per lane), out-of-range detection and a configurable read latency per port.
// It is used as the video/shadow memory between the Z80 bus decoder (port A)
// and the video scan-out / ESP32 bridge (port B).
//
// Parameters
//   DATA_W    data width per port (multiple of LANE_W)
//   LANE_W    bits covered by one write-enable lane
//   DEPTH     number of words (any value, need not be a power of two)
//   ADDR_W    address width, 2**ADDR_W >= DEPTH
//   RD_LAT_A  port A read latency, 1 or 2
//   RD_LAT_B  port B read latency, 1 or 2
//
// Ports (x = a or b)
//   clk        single clock for both ports
//   reset      synchronous, active-high
//   x_en       access request
//   x_we       lane write enables, all zero = read
//   x_addr     word address
//   x_din      write data
//   x_dout     read data, holds its last value while x_valid is low
//   x_valid    one-cycle strobe: x_dout holds a read result
//   x_oob      qualifies x_valid: the read address was >= DEPTH
//   collision  one-cycle pulse: same-address writes with overlapping lanes
//   oob_cnt    saturating count of out-of-range accesses (both ports)
// -----------------------------------------------------------------------------
module dpram_nibble_pipe #(
    parameter int DATA_W   = 4,
    parameter int LANE_W   = 4,
    parameter int DEPTH    = 20480,
    parameter int ADDR_W   = 15,
    parameter int RD_LAT_A = 1,
    parameter int RD_LAT_B = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    // port A
    input  logic                       a_en,
    input  logic [DATA_W/LANE_W-1:0]   a_we,
    input  logic [ADDR_W-1:0]          a_addr,
    input  logic [DATA_W-1:0]          a_din,
    output logic [DATA_W-1:0]          a_dout,
    output logic                       a_valid,
    output logic                       a_oob,
    // port B
    input  logic                       b_en,
    input  logic [DATA_W/LANE_W-1:0]   b_we,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic [DATA_W-1:0]          b_din,
    output logic [DATA_W-1:0]          b_dout,
    output logic                       b_valid,
    output logic                       b_oob,
    // status
    output logic                       collision,
    output logic [7:0]                 oob_cnt
);

    localparam int LANES  = DATA_W / LANE_W;
    // Bits needed to index the storage array itself; the upper address
    // values that do not map to a word are caught by the range check.
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    // Storage. Contents are deliberately not reset so the array maps onto
    // block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    // Per-port views of the two request interfaces, index 0 = A, 1 = B, so
    // the read path can be written once in a generate loop.
    logic              en_p     [2];
    logic [LANES-1:0]  we_p     [2];
    logic [ADDR_W-1:0] addr_p   [2];
    logic [DATA_W-1:0] din_p    [2];
    logic              in_range [2];
    logic              rd_req   [2];
    logic              wr_ok    [2];
    logic              oob_acc  [2];
    logic [DATA_W-1:0] wmask    [2];
    logic [DATA_W-1:0] dout_p   [2];
    logic              valid_p  [2];
    logic              oob_p    [2];

    assign en_p[0]   = a_en;
    assign we_p[0]   = a_we;
    assign addr_p[0] = a_addr;
    assign din_p[0]  = a_din;
    assign en_p[1]   = b_en;
    assign we_p[1]   = b_we;
    assign addr_p[1] = b_addr;
    assign din_p[1]  = b_din;

    // Expand a lane-enable vector into a bit mask over the data word.
    function automatic logic [DATA_W-1:0] lane_expand(input logic [LANES-1:0] we);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int l = 0; l < LANES; l++) begin
            m[l*LANE_W +: LANE_W] = {LANE_W{we[l]}};
        end
        return m;
    endfunction

    genvar gi;

    // -------------------------------------------------------------------------
    // Request decode per port
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            assign in_range[gi] = ({1'b0, addr_p[gi]} < DEPTH_X);
            assign rd_req[gi]   = en_p[gi] && (we_p[gi] == '0);
            assign wr_ok[gi]    = en_p[gi] && (we_p[gi] != '0) && in_range[gi];
            assign oob_acc[gi]  = en_p[gi] && !in_range[gi];
            assign wmask[gi]    = lane_expand(we_p[gi]);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Memory write. B is applied before A inside the same block so that,
    // where both ports enable the same lane of the same word, A's
    // non-blocking assignment lands last and wins.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_ok[1] && we_p[1][l]) begin
                    mem[addr_p[1][MEM_AW-1:0]][l*LANE_W +: LANE_W] <= din_p[1][l*LANE_W +: LANE_W];
                end
                if (wr_ok[0] && we_p[0][l]) begin
                    mem[addr_p[0][MEM_AW-1:0]][l*LANE_W +: LANE_W] <= din_p[0][l*LANE_W +: LANE_W];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path per port.
    //
    // The array read returns the pre-write word. Alongside it we register a
    // per-bit override mask and override data: the other port's write lanes
    // when it writes the same in-range address in the same cycle, or all
    // ones / zero for an out-of-range read. Merging after the register gives
    // write-first behaviour without a combinational path through the RAM.
    // A port that reads cannot also write, so only the other port's write
    // needs forwarding; when both ports write there is no read to forward to.
    //
    // All stage-1 registers load only on a read, so the merged word holds
    // while valid is low. Reset sets the override to all-zero data so dout
    // reads 0 without having to reset the RAM output register.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam int OT  = 1 - gi;
            localparam int LAT = (gi == 0) ? RD_LAT_A : RD_LAT_B;

            logic [DATA_W-1:0] raw_reg;
            logic [DATA_W-1:0] fwd_mask_reg;
            logic [DATA_W-1:0] fwd_data_reg;
            logic              valid1_reg;
            logic              oob1_reg;
            logic [DATA_W-1:0] merged;

            // Registered RAM read, kept free of reset for block RAM mapping.
            always_ff @(posedge clk) begin
                if (rd_req[gi] && in_range[gi]) begin
                    raw_reg <= mem[addr_p[gi][MEM_AW-1:0]];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    fwd_mask_reg <= '1;
                    fwd_data_reg <= '0;
                    valid1_reg   <= 1'b0;
                    oob1_reg     <= 1'b0;
                end else begin
                    valid1_reg <= rd_req[gi];
                    oob1_reg   <= rd_req[gi] && !in_range[gi];
                    if (rd_req[gi]) begin
                        if (!in_range[gi]) begin
                            fwd_mask_reg <= '1;
                            fwd_data_reg <= '0;
                        end else if (wr_ok[OT] && (addr_p[OT] == addr_p[gi])) begin
                            fwd_mask_reg <= wmask[OT];
                            fwd_data_reg <= din_p[OT];
                        end else begin
                            fwd_mask_reg <= '0;
                            fwd_data_reg <= '0;
                        end
                    end
                end
            end

            assign merged = (raw_reg & ~fwd_mask_reg) | (fwd_data_reg & fwd_mask_reg);

            if (LAT == 2) begin : g_lat2
                logic [DATA_W-1:0] dout2_reg;
                logic              valid2_reg;
                logic              oob2_reg;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        dout2_reg  <= '0;
                        valid2_reg <= 1'b0;
                        oob2_reg   <= 1'b0;
                    end else begin
                        valid2_reg <= valid1_reg;
                        oob2_reg   <= oob1_reg;
                        if (valid1_reg) begin
                            dout2_reg <= merged;
                        end
                    end
                end

                assign dout_p[gi]  = dout2_reg;
                assign valid_p[gi] = valid2_reg;
                assign oob_p[gi]   = oob2_reg;
            end else begin : g_lat1
                assign dout_p[gi]  = merged;
                assign valid_p[gi] = valid1_reg;
                assign oob_p[gi]   = oob1_reg;
            end
        end
    endgenerate

    assign a_dout  = dout_p[0];
    assign a_valid = valid_p[0];
    assign a_oob   = oob_p[0];
    assign b_dout  = dout_p[1];
    assign b_valid = valid_p[1];
    assign b_oob   = oob_p[1];

    // -------------------------------------------------------------------------
    // Collision flag and out-of-range counter
    // -------------------------------------------------------------------------
    logic       collision_reg;
    logic       collision_next;
    logic [7:0] oob_cnt_reg;
    logic [7:0] oob_cnt_next;
    logic [8:0] oob_sum;

    always_comb begin
        collision_next = wr_ok[0] && wr_ok[1] && (addr_p[0] == addr_p[1])
                         && ((we_p[0] & we_p[1]) != '0);
        oob_sum        = {1'b0, oob_cnt_reg} + {8'd0, oob_acc[0]} + {8'd0, oob_acc[1]};
        oob_cnt_next   = oob_sum[8] ? 8'hFF : oob_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            collision_reg <= 1'b0;
            oob_cnt_reg   <= 8'd0;
        end else begin
            collision_reg <= collision_next;
            oob_cnt_reg   <= oob_cnt_next;
        end
    end

    assign collision = collision_reg;
    assign oob_cnt   = oob_cnt_reg;

endmodule
